// File: rtl/legv8_instr_encoder.sv
// LEGv8 instruction-word encoder: packs per-class fields into 32-bit words for instruction memory.
// Optional `LEGV8_OPCODE_CHECK_EN` also rejects opcodes that do not belong to the bundle's class.
module legv8_instr_encoder #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned START_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_class,
  input  logic [10:0]           in_opcode,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rn,
  input  logic [4:0]            in_rm,
  input  logic [5:0]            in_shamt,
  input  logic [1:0]            in_hw,
  input  logic [31:0]           in_imm,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_instr,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  err_range,
  output logic                  wrapped,
  output logic                  done
);

  localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);
  localparam logic [ADDR_WIDTH-1:0] LastAddr  = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [31:0]           word;
  logic                  range_ok;
  logic                  op_ok;
  logic                  legal;
  logic                  accept;
  logic                  emit;

  assign in_ready = (state_q == StRun) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign legal    = range_ok && op_ok;
  assign emit     = accept && legal;

  // Signed ranges are checked as "upper bits are a sign extension of the field".
  always_comb begin
    word     = '0;
    range_ok = 1'b0;
    unique case (in_class)
      3'd0: begin
        word     = {in_opcode, in_rm, in_shamt, in_rn, in_rd};
        range_ok = 1'b1;
      end
      3'd1: begin
        word     = {in_opcode[10:1], in_imm[11:0], in_rn, in_rd};
        range_ok = (in_imm[31:11] == {21{in_imm[11]}});
      end
      3'd2: begin
        word     = {in_opcode, in_imm[8:0], 2'b00, in_rn, in_rd};
        range_ok = (in_imm[31:8] == {24{in_imm[8]}});
      end
      3'd3: begin
        word     = {in_opcode[10:3], in_imm[18:0], in_rd};
        range_ok = (in_imm[31:18] == {14{in_imm[18]}});
      end
      3'd4: begin
        word     = {in_opcode[10:5], in_imm[25:0]};
        range_ok = (in_imm[31:25] == {7{in_imm[25]}});
      end
      3'd5: begin
        word     = {in_opcode[10:2], in_hw, in_imm[15:0], in_rd};
        range_ok = (in_imm[31:16] == 16'h0000);
      end
      default: begin
        word     = '0;
        range_ok = 1'b0;
      end
    endcase
  end

`ifdef LEGV8_OPCODE_CHECK_EN
  always_comb begin
    op_ok = 1'b1;
    unique case (in_class)
      3'd2:    op_ok = (in_opcode == 11'b11111000000) || (in_opcode == 11'b11111000010);
      3'd3:    op_ok = (in_opcode[10:3] == 8'b10110100) || (in_opcode[10:3] == 8'b10110101);
      3'd4:    op_ok = (in_opcode[10:5] == 6'b000101) || (in_opcode[10:5] == 6'b100101);
      3'd5:    op_ok = (in_opcode[10:2] == 9'b111100101);
      default: op_ok = 1'b1;
    endcase
  end
`else
  assign op_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= StartAddr;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_addr  <= '0;
      err_range <= 1'b0;
      wrapped   <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q   <= StRun;
            cnt_q     <= StartAddr;
            err_range <= 1'b0;
            wrapped   <= 1'b0;
            done      <= 1'b0;
          end
        end
        StRun: begin
          if (accept && in_last) state_q <= StDrain;
        end
        StDrain: begin
          if (!out_valid || out_ready) begin
            state_q <= StDone;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase

      // A new emit may coincide with the drain of the held word; the emit wins the register.
      if (emit) begin
        out_valid <= 1'b1;
        out_instr <= word;
        out_addr  <= cnt_q;
        cnt_q     <= cnt_q + 1'b1;
        if (cnt_q == LastAddr) wrapped <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      if (accept && !legal) err_range <= 1'b1;
    end
  end

endmodule

// File: doc/legv8_instr_encoder.md
Name: legv8_instr_encoder

Overview:
- Producer side of the instruction-word interface consumed by the instruction decoder: packs per-class fields (R, I, D, CB, B, MOVK) into 32-bit LEGv8 words.
- Checks immediate ranges and emits words with sequential instruction-memory write addresses over a valid/ready stream.
- Used by the program loader to fill instruction memory before the core runs.

Parameters:
ADDR_WIDTH, 6, instruction-memory word-address width
START_ADDR, 0, first write address after each start

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high
start  input  1  single-cycle pulse that begins a load session
in_valid  input  1  field bundle valid
in_ready  output  1  encoder accepts bundle this cycle
in_class  input  3  0=R 1=I 2=D 3=CB 4=B 5=MOVK, 6-7 illegal
in_opcode  input  11  opcode, left-aligned (upper bits used per class)
in_rd  input  5  Rd/Rt field
in_rn  input  5  Rn field
in_rm  input  5  Rm field
in_shamt  input  6  R-type shamt
in_hw  input  2  MOVK shift select
in_imm  input  32  signed immediate / offset
in_last  input  1  final bundle of session
out_valid  output  1  encoded word valid
out_ready  input  1  memory side accepts word
out_instr  output  32  encoded word
out_addr  output  ADDR_WIDTH  write address of out_instr
err_range  output  1  sticky: immediate out of range or illegal class
wrapped  output  1  sticky: address counter wrapped
done  output  1  session complete

Behaviour:
- Clock and reset: clk only; reset is synchronous and active-high.
- Reset values: state=IDLE; out_valid=0; out_instr=0; out_addr=0; addr counter=START_ADDR; err_range=0; wrapped=0; done=0. Reset mid-session discards any held word.
- in_ready = (state==RUN) && (!out_valid || out_ready). Single output register, no skid; accept-to-out_valid latency is 1 cycle.
- Encodings (in_rd -> [4:0], in_rn -> [9:5] where present):
  - R: [31:21]=op[10:0], [20:16]=rm, [15:10]=shamt.
  - I: [31:22]=op[10:1], [21:10]=imm[11:0]; signed range -2048..2047.
  - D: [31:21]=op, [20:12]=imm[8:0], [11:10]=00; range -256..255.
  - CB: [31:24]=op[10:3], [23:5]=imm[18:0]; range -2^18..2^18-1; rn unused.
  - B: [31:26]=op[10:5], [25:0]=imm[25:0]; range -2^25..2^25-1.
  - MOVK: [31:23]=op[10:2], [22:21]=hw, [20:5]=imm[15:0]; unsigned range 0..65535.
- Range violation or class 6/7 on an accepted bundle:
  - Bundle is consumed; no word is emitted; address is not advanced; err_range is set.
  - If that bundle carries in_last, the session still ends (go to DONE once the output register is empty).
- Address: out_addr takes the counter value on accept. The counter increments only on an emitted word. Wrap from 2^ADDR_WIDTH-1 to 0 sets wrapped.
- State machine:
  - IDLE: in_ready=0. start -> RUN; counter=START_ADDR; err_range=0; wrapped=0; done=0.
  - RUN: accepted bundle with in_last -> DRAIN.
  - DRAIN: in_ready=0; when out_valid=0, or out_valid&&out_ready -> DONE.
  - DONE: done=1; start -> RUN with the same clears as IDLE.
- start in RUN/DRAIN is ignored. Output word is held stable while out_valid&&!out_ready. Simultaneous output drain and new accept in the same cycle is legal and loses no data.

Optional Feature:
LEGV8_OPCODE_CHECK_EN
- Defined: opcode is also validated per class; a mismatch is treated exactly like a range violation (consumed, not emitted, err_range set).
  - B: op[10:5] must be 000101 or 100101.
  - CB: op[10:3] must be 10110100 or 10110101.
  - D: op must be 11111000000 or 11111000010.
  - MOVK: op[10:2] must be 111100101.
- Undefined: opcode bits are passed through unchecked.

Test Plan:
- start; R, op=10001011000, rm=2, shamt=0, rn=1, rd=3, in_last=0 -> next cycle out_valid=1, out_instr=0x8B020023, out_addr=0.
- D, op=11111000010, imm=8, rn=2, rd=5 -> out_instr=0xF8408045, out_addr=1. Then B, op=000101xxxxx, imm=-1, in_last=1 -> 0x17FFFFFF at addr 2, then done=1.
- D, imm=256 -> no out_valid, err_range=1, next emitted word still uses the unadvanced address. MOVK imm=65535 -> accepted, no error.
- Hold out_ready=0 with a word pending -> in_ready=0, out_instr stable for 5 cycles. Raise out_ready with in_valid=1 -> drain and accept in the same cycle, no word lost.
- ADDR_WIDTH=2; 5 legal bundles -> out_addr 0,1,2,3,0; wrapped=1 after the 5th emission.
- Reset asserted while a word is held -> next cycle out_valid=0, state IDLE, in_ready=0 until start.
